// File: rtl/pdm_mic_capture.sv
// rtl/pdm_mic_capture.sv - PDM microphone clock, boxcar decimator, PCM valid/ack output (optional PCM_DC_BLOCK_EN)
module pdm_mic_capture #(
  parameter int CLK_HALF = 25,
  parameter int DECIM    = 64,
  parameter int OUT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pdm_data,
  output logic             mic_clk,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ack,
  output logic             overrun,
  output logic             busy
);

  localparam int LOG2_D = $clog2(DECIM);
  localparam int DIV_W  = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int ONES_W = LOG2_D + 1;
  // A half-full window offset of DECIM/2 maps to exactly 2^(OUT_W-1), so full
  // windows land one LSB past the positive rail and are clipped by saturation.
  localparam int SHIFT  = OUT_W - LOG2_D;
  localparam int EXT_W  = OUT_W + 2;
  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;

  logic              pdm_m, pdm_s;
  logic [DIV_W-1:0]  div_cnt;
  logic [LOG2_D-1:0] bit_cnt;
  logic [ONES_W-1:0] ones, ones_next, win_total;
  logic              win_done;
  logic              div_term, rise, bit_last;
  logic signed [EXT_W-1:0] total_ext, box_raw;
  logic              load;
  logic [OUT_W-1:0]  load_value;

  function automatic logic [OUT_W-1:0] sat(input logic signed [EXT_W-1:0] v);
    if (v > SAT_HI)      return SAT_HI[OUT_W-1:0];
    else if (v < SAT_LO) return SAT_LO[OUT_W-1:0];
    else                 return v[OUT_W-1:0];
  endfunction

  assign div_term  = (div_cnt == DIV_W'(CLK_HALF - 1));
  assign rise      = enable && div_term && !mic_clk;
  assign bit_last  = (bit_cnt == LOG2_D'(DECIM - 1));
  assign ones_next = ones + ONES_W'(pdm_s);
  assign total_ext = signed'({{(EXT_W - ONES_W){1'b0}}, win_total});
  assign box_raw   = (total_ext - EXT_W'(DECIM / 2)) <<< SHIFT;

  // Two-flop synchronizer for the asynchronous PDM bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pdm_m <= 1'b0;
      pdm_s <= 1'b0;
    end else begin
      pdm_m <= pdm_data;
      pdm_s <= pdm_m;
    end
  end

  // Mic clock divider and bit capture on each registered mic_clk rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      mic_clk   <= 1'b0;
      bit_cnt   <= '0;
      ones      <= '0;
      win_total <= '0;
      win_done  <= 1'b0;
    end else begin
      // A window closed on the last enabled cycle is still delivered
      win_done <= rise && bit_last;
      if (!enable) begin
        div_cnt <= '0;
        mic_clk <= 1'b0;
        bit_cnt <= '0;
        ones    <= '0;
      end else begin
        if (div_term) begin
          div_cnt <= '0;
          mic_clk <= ~mic_clk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        if (rise) begin
          bit_cnt <= bit_cnt + LOG2_D'(1);
          if (bit_last) begin
            ones      <= '0;
            win_total <= ones_next;
          end else begin
            ones <= ones_next;
          end
        end
      end
    end
  end

`ifdef PCM_DC_BLOCK_EN
  logic [OUT_W-1:0]        x_reg, x_prev, y_prev;
  logic                    x_valid;
  logic signed [EXT_W-1:0] x_ext, xp_ext, yp_ext, dc_raw;

  assign x_ext  = EXT_W'(signed'(x_reg));
  assign xp_ext = EXT_W'(signed'(x_prev));
  assign yp_ext = EXT_W'(signed'(y_prev));
  assign dc_raw = x_ext - xp_ext + yp_ext - (yp_ext >>> 8);

  // DC-block high-pass stage, one extra cycle after the boxcar result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg   <= '0;
      x_valid <= 1'b0;
      x_prev  <= '0;
      y_prev  <= '0;
    end else begin
      x_valid <= win_done;
      if (win_done) x_reg <= sat(box_raw);
      if (!enable) begin
        x_prev <= '0;
        y_prev <= '0;
      end else if (x_valid) begin
        x_prev <= x_reg;
        y_prev <= sat(dc_raw);
      end
    end
  end

  assign load       = x_valid;
  assign load_value = sat(dc_raw);
`else
  assign load       = win_done;
  assign load_value = sat(box_raw);
`endif

  // Output sample register with valid/ack handshake and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (load) begin
      sample       <= load_value;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ack) overrun <= 1'b1;
    end else if (sample_valid && sample_ack) begin
      sample_valid <= 1'b0;
    end
  end

  // Busy follows enable, one cycle late
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= 1'b0;
    else        busy <= enable;
  end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// tb/tb_pdm_mic_capture.sv - directed self-checking bench for pdm_mic_capture
module tb_pdm_mic_capture;

  logic        clk = 1'b0;
  logic        reset, enable, pdm_data, sample_ack;
  logic        mic_clk, sample_valid, overrun, busy;
  logic [15:0] sample;
  int          tests = 0;
  int          fails = 0;
  int          n;

  pdm_mic_capture dut (
    .clk(clk), .reset(reset), .enable(enable), .pdm_data(pdm_data),
    .mic_clk(mic_clk), .sample(sample), .sample_valid(sample_valid),
    .sample_ack(sample_ack), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count clock edges until mic_clk reaches level; sampled 1ns after each edge
  task automatic count_until(input logic level, output int edges);
    edges = 0;
    while (mic_clk !== level && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    if (mic_clk !== level) begin
      tests++;
      fails++;
      $display("FAIL mic_clk_timeout: observed %b expected %b", mic_clk, level);
    end
  endtask

  task automatic wait_rise();
    int e;
    count_until(1'b0, e);
    count_until(1'b1, e);
  endtask

  task automatic rises(input int k);
    for (int i = 0; i < k; i++) wait_rise();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pdm_data = 1'b1; sample_ack = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mic_clk", mic_clk, 0);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Window 1: all ones, first rise timing and 50 clk period
    enable = 1'b1;
    count_until(1'b1, n);
    check("first_rise_delay", n, 25);
    check("busy_on", busy, 1);
    count_until(1'b0, n);
    check("mic_clk_high", n, 25);
    count_until(1'b1, n);
    check("mic_clk_low", n, 25);
    rises(62);
    check("w1_valid_at_64th", sample_valid, 0);
    @(posedge clk); #1;
    check("w1_valid", sample_valid, 1);
    check("w1_sample_ones", sample, 16'h7FFF);
    check("w1_overrun", overrun, 0);
    pdm_data = 1'b0;
    sample_ack = 1'b1;
    @(posedge clk); #1;
    sample_ack = 1'b0;
    check("w1_ack_clears", sample_valid, 0);

    // Window 2: all zeros, left unacknowledged
    rises(64);
    @(posedge clk); #1;
    check("w2_sample_zeros", sample, 16'h8000);
    check("w2_valid", sample_valid, 1);

    // Window 3: alternating bits, ack coincident with load
    pdm_data = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wait_rise();
      pdm_data = ~pdm_data;
    end
    pdm_data = 1'b1;
    sample_ack = 1'b1;
    @(posedge clk); #1;
    sample_ack = 1'b0;
    check("w3_sample_alt", sample, 16'h0000);
    check("w3_valid_kept", sample_valid, 1);
    check("w3_no_overrun", overrun, 0);

    // Window 4: overwrite without ack
    rises(64);
    @(posedge clk); #1;
    check("w4_sample", sample, 16'h7FFF);
    check("w4_valid", sample_valid, 1);
    check("w4_overrun", overrun, 1);

    // Window 5: disable after 30 bits, idle, re-enable
    pdm_data = 1'b0;
    rises(30);
    enable = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_mic_clk", mic_clk, 0);
    check("idle_busy", busy, 0);
    repeat (100) @(posedge clk); #1;
    check("idle_sample_held", sample, 16'h7FFF);
    check("idle_valid_held", sample_valid, 1);
    check("idle_overrun_held", overrun, 1);
    sample_ack = 1'b1;
    @(posedge clk); #1;
    sample_ack = 1'b0;
    check("idle_ack", sample_valid, 0);
    pdm_data = 1'b1;
    repeat (5) @(posedge clk); #1;
    enable = 1'b1;
    count_until(1'b1, n);
    check("reen_first_rise", n, 25);
    rises(63);
    check("reen_no_partial", sample_valid, 0);
    @(posedge clk); #1;
    check("reen_valid", sample_valid, 1);
    check("reen_sample", sample, 16'h7FFF);

    // Async reset mid-window with a sample held
    rises(10);
    reset = 1'b0;
    #1;
    check("arst_mic_clk", mic_clk, 0);
    check("arst_sample", sample, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    count_until(1'b1, n);
    check("post_rst_first_rise", n, 25);
    rises(63);
    @(posedge clk); #1;
    check("post_rst_valid", sample_valid, 1);
    check("post_rst_sample", sample, 16'h7FFF);
    check("post_rst_overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
